mmio_uart_tx: RTL

MMIO_UART_TX -- requirements
Module: mmio_uart_tx

---
 rtl/mmio_uart_tx.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: data/status registers, TX FIFO and 8N1 serializer.
// ftdi_tx idles high and comes straight from a flop.
module mmio_uart_tx #(
  parameter logic [15:0] BASE_ADDR  = 16'hFF00,
  parameter int          CLK_DIV    = 868,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] i_addr,
  input  logic [7:0]  i_data,
  input  logic        i_wr,
  output logic [7:0]  o_data,
  output logic        o_sel,
  output logic        ftdi_tx
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] DEPTH    = CW'(FIFO_DEPTH);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [15:0]   STAT     = BASE_ADDR + 16'd1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nxt;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic          ovf, full, empty, busy;
  logic [DW-1:0] div, div_nxt;
  logic [2:0]    bit_idx, bit_nxt;
  logic [7:0]    shift, shift_nxt;
  logic          tx_nxt;
  logic          pop, push_req, push, clr, ovf_set;

  assign full     = (count == DEPTH);
  assign empty    = (count == '0);
  assign busy     = (state != IDLE);
  assign push_req = i_wr && (i_addr == BASE_ADDR);
  assign push     = push_req && (!full || pop);
  assign ovf_set  = push_req && !push;
  assign clr      = i_wr && (i_addr == STAT);
  assign o_sel    = (i_addr == BASE_ADDR) || (i_addr == STAT);

  always_comb begin
    o_data = 8'h00;
    if (i_addr == STAT)
      o_data = {4'b0, ovf, busy, empty, full};
  end

  always_comb begin
    state_nxt = state;
    div_nxt   = div;
    bit_nxt   = bit_idx;
    shift_nxt = shift;
    tx_nxt    = ftdi_tx;
    pop       = 1'b0;
    unique case (state)
      IDLE: begin
        tx_nxt  = 1'b1;
        div_nxt = '0;
        bit_nxt = '0;
        if (!empty) begin
          pop       = 1'b1;
          shift_nxt = mem[rptr];
          state_nxt = START;
          tx_nxt    = 1'b0;
        end
      end
      START: begin
        if (div == DIV_LAST) begin
          div_nxt   = '0;
          state_nxt = DATA;
          tx_nxt    = shift[0];
          shift_nxt = {1'b0, shift[7:1]};
        end else begin
          div_nxt = div + 1'b1;
        end
      end
      DATA: begin
        if (div == DIV_LAST) begin
          div_nxt = '0;
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
            tx_nxt    = 1'b1;
          end else begin
            bit_nxt   = bit_idx + 3'd1;
            tx_nxt    = shift[0];
            shift_nxt = {1'b0, shift[7:1]};
          end
        end else begin
          div_nxt = div + 1'b1;
        end
      end
      STOP: begin
        if (div == DIV_LAST) begin
          div_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          div_nxt = div + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      div     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      ftdi_tx <= 1'b1;
    end else begin
      state   <= state_nxt;
      div     <= div_nxt;
      bit_idx <= bit_nxt;
      shift   <= shift_nxt;
      ftdi_tx <= tx_nxt;
    end
  end

  // A push into a full FIFO still lands when the head leaves the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (ovf_set)  ovf <= 1'b1;
      else if (clr) ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= i_data;
  end

endmodule
